// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - DMI op/resp enums, register addresses, dmcontrol/dmstatus layouts, FSM states
package dm_pkg;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_SUCCESS = 2'd0,
    DMI_FAILED  = 2'd2
  } dmi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmi_state_e;

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;

  // dmcontrol write-side bit positions
  localparam int DMC_HALTREQ      = 31;
  localparam int DMC_RESUMEREQ    = 30;
  localparam int DMC_HARTRESET    = 29;
  localparam int DMC_ACKHAVERESET = 28;
  localparam int DMC_SETRESETHALT = 3;
  localparam int DMC_CLRRESETHALT = 2;
  localparam int DMC_NDMRESET     = 1;
  localparam int DMC_DMACTIVE     = 0;

  typedef struct packed {
    logic        haltreq;
    logic        resumereq;
    logic        hartreset;
    logic        ackhavereset;
    logic [23:0] zero;
    logic        setresethaltreq;
    logic        clrresethaltreq;
    logic        ndmreset;
    logic        dmactive;
  } dmcontrol_t;

  typedef struct packed {
    logic [11:0] zero_hi;
    logic        allhavereset;
    logic        anyhavereset;
    logic        allresumeack;
    logic        anyresumeack;
    logic [3:0]  zero_mid;
    logic        allrunning;
    logic        anyrunning;
    logic        allhalted;
    logic        anyhalted;
    logic        authenticated;
    logic [2:0]  zero_lo;
    logic [3:0]  version;
  } dmstatus_t;

endpackage

// File: rtl/debug_module_if.sv
// rtl/debug_module_if.sv - DMI request/response channel between debug transport and DM
interface debug_module_if #(parameter int ABITS = 7);
  logic             dmi_req_valid;
  logic             dmi_req_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic [1:0]       dmi_req_op;
  logic             dmi_rsp_valid;
  logic             dmi_rsp_ready;
  logic [31:0]      dmi_rsp_data;
  logic [1:0]       dmi_rsp_resp;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready,
    input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_resp
  );

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_rsp_ready,
    output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_resp
  );
endinterface

// File: rtl/dm_dmi_slave.sv
// rtl/dm_dmi_slave.sv - DMI request/response FSM with capture and response registers
module dm_dmi_slave
  import dm_pkg::*;
#(
  parameter int ABITS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  debug_module_if.slave    dmi,
  output logic             acc_wr,
  output logic [ABITS-1:0] acc_addr,
  output logic [31:0]      acc_wdata,
  input  logic [31:0]      rd_data
);

  dmi_state_e       state_q, state_d;
  logic [ABITS-1:0] addr_q;
  logic [31:0]      data_q;
  dmi_op_e          op_q;
  logic [31:0]      rsp_data_q;
  dmi_resp_e        rsp_resp_q;

  // State register, request capture in IDLE, response capture in ACCESS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= DMI_NOP;
      rsp_data_q <= '0;
      rsp_resp_q <= DMI_SUCCESS;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && dmi.dmi_req_valid) begin
        addr_q <= dmi.dmi_req_addr;
        data_q <= dmi.dmi_req_data;
        op_q   <= dmi_op_e'(dmi.dmi_req_op);
      end
      if (state_q == ST_ACCESS) begin
        rsp_data_q <= (op_q == DMI_READ) ? rd_data : 32'h0;
        rsp_resp_q <= (op_q == DMI_RSVD) ? DMI_FAILED : DMI_SUCCESS;
      end
    end
  end

  // Next-state and handshake outputs; ACCESS is the single register-access cycle
  always_comb begin
    state_d           = state_q;
    dmi.dmi_req_ready = 1'b0;
    dmi.dmi_rsp_valid = 1'b0;
    acc_wr            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmi.dmi_req_ready = 1'b1;
        if (dmi.dmi_req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        acc_wr  = (op_q == DMI_WRITE);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        dmi.dmi_rsp_valid = 1'b1;
        if (dmi.dmi_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dmi.dmi_rsp_data = rsp_data_q;
  assign dmi.dmi_rsp_resp = rsp_resp_q;
  assign acc_addr         = addr_q;
  assign acc_wdata        = data_q;

endmodule

// File: rtl/debug_module.sv
// rtl/debug_module.sv - RISC-V debug module top (register file, run control); optional DM_HARTRESET_EN
module debug_module
  import dm_pkg::*;
#(
  parameter int         ABITS      = 7,
  parameter logic [3:0] DM_VERSION = 4'd2
) (
  input  logic          clk,
  input  logic          rst_n,
  debug_module_if.slave dmi,
  output logic          haltreq,
  output logic          resumereq,
  output logic          resethaltreq,
  output logic          ndmreset,
  output logic          hartreset,
  input  logic          hart_halted,
  input  logic          hart_resumeack,
  input  logic          hart_havereset
);

  logic             acc_wr;
  logic [ABITS-1:0] acc_addr;
  logic [31:0]      acc_wdata;
  logic [31:0]      rd_data;

  logic        dmactive_q, haltreq_q, ndmreset_q, resumereq_q;
  logic        resethalt_q, resumeack_q, havereset_q;
  logic [31:0] data0_q;
  logic        ctl_wr, data0_wr, deactivate, ndm_fall, hr_fall;
  dmcontrol_t  rd_ctl;
  dmstatus_t   rd_sts;

  dm_dmi_slave #(.ABITS(ABITS)) u_slave (
    .clk       (clk),
    .rst_n     (rst_n),
    .dmi       (dmi),
    .acc_wr    (acc_wr),
    .acc_addr  (acc_addr),
    .acc_wdata (acc_wdata),
    .rd_data   (rd_data)
  );

  assign ctl_wr     = acc_wr && (acc_addr == ABITS'(ADDR_DMCONTROL));
  assign data0_wr   = acc_wr && (acc_addr == ABITS'(ADDR_DATA0));
  assign deactivate = !dmactive_q || (ctl_wr && !acc_wdata[DMC_DMACTIVE]);
  assign ndm_fall   = ctl_wr && ndmreset_q && !acc_wdata[DMC_NDMRESET];

`ifdef DM_HARTRESET_EN
  logic hartreset_q;
  assign hr_fall = ctl_wr && hartreset_q && !acc_wdata[DMC_HARTRESET];

  // hartreset bit is a plain RW control while the DM is active
  always_ff @(posedge clk) begin
    if (!rst_n || deactivate) hartreset_q <= 1'b0;
    else if (ctl_wr)          hartreset_q <= acc_wdata[DMC_HARTRESET];
  end
  assign hartreset = hartreset_q;
`else
  assign hr_fall   = 1'b0;
  assign hartreset = 1'b0;
`endif

  // dmactive is the only state a write can change while the DM is inactive
  always_ff @(posedge clk) begin
    if (!rst_n)      dmactive_q <= 1'b0;
    else if (ctl_wr) dmactive_q <= acc_wdata[DMC_DMACTIVE];
  end

  // Register file and run-control flags, all held clear while inactive
  always_ff @(posedge clk) begin
    if (!rst_n || deactivate) begin
      data0_q     <= '0;
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      resumereq_q <= 1'b0;
      resumeack_q <= 1'b0;
      resethalt_q <= 1'b0;
      havereset_q <= 1'b0;
    end else begin
      if (data0_wr) data0_q <= acc_wdata;
      if (ctl_wr) begin
        haltreq_q  <= acc_wdata[DMC_HALTREQ];
        ndmreset_q <= acc_wdata[DMC_NDMRESET];
      end
      if (hart_resumeack) begin
        resumereq_q <= 1'b0;
        resumeack_q <= 1'b1;
      end
      // A resume written alongside a halt request is dropped
      if (ctl_wr && acc_wdata[DMC_RESUMEREQ] && !acc_wdata[DMC_HALTREQ]) begin
        resumereq_q <= 1'b1;
        resumeack_q <= 1'b0;
      end
      if (ctl_wr && acc_wdata[DMC_SETRESETHALT]) resethalt_q <= 1'b1;
      if (ctl_wr && acc_wdata[DMC_CLRRESETHALT]) resethalt_q <= 1'b0;
      // Set events are ordered after the acknowledge so they win on collision
      if (ctl_wr && acc_wdata[DMC_ACKHAVERESET]) havereset_q <= 1'b0;
      if (hart_havereset || ndm_fall || hr_fall) havereset_q <= 1'b1;
    end
  end

  // Read-data assembly for the addressed register
  always_comb begin
    rd_ctl           = '0;
    rd_ctl.haltreq   = haltreq_q;
    rd_ctl.hartreset = hartreset;
    rd_ctl.ndmreset  = ndmreset_q;
    rd_ctl.dmactive  = dmactive_q;

    rd_sts               = '0;
    rd_sts.version       = DM_VERSION;
    rd_sts.authenticated = 1'b1;
    rd_sts.anyhalted     = hart_halted;
    rd_sts.allhalted     = hart_halted;
    rd_sts.anyrunning    = !hart_halted;
    rd_sts.allrunning    = !hart_halted;
    rd_sts.anyresumeack  = resumeack_q;
    rd_sts.allresumeack  = resumeack_q;
    rd_sts.anyhavereset  = havereset_q;
    rd_sts.allhavereset  = havereset_q;

    rd_data = 32'h0;
    case (acc_addr)
      ABITS'(ADDR_DATA0):      rd_data = data0_q;
      ABITS'(ADDR_DMCONTROL):  rd_data = rd_ctl;
      ABITS'(ADDR_DMSTATUS):   rd_data = rd_sts;
      ABITS'(ADDR_HARTINFO):   rd_data = 32'h0;
      ABITS'(ADDR_ABSTRACTCS): rd_data = 32'h0000_0001;
      default:                 rd_data = 32'h0;
    endcase
  end

  assign haltreq      = haltreq_q;
  assign resumereq    = resumereq_q;
  assign resethaltreq = resethalt_q;
  assign ndmreset     = ndmreset_q;

endmodule

// File: tb/tb_debug_module.sv
// tb/tb_debug_module.sv - directed self-checking bench for debug_module
module tb_debug_module;

  logic clk = 1'b0;
  logic rst_n;
  logic haltreq, resumereq, resethaltreq, ndmreset, hartreset;
  logic hart_halted, hart_resumeack, hart_havereset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  debug_module_if #(.ABITS(7)) dmi ();

  debug_module #(.ABITS(7), .DM_VERSION(4'd2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dmi            (dmi),
    .haltreq        (haltreq),
    .resumereq      (resumereq),
    .resethaltreq   (resethaltreq),
    .ndmreset       (ndmreset),
    .hartreset      (hartreset),
    .hart_halted    (hart_halted),
    .hart_resumeack (hart_resumeack),
    .hart_havereset (hart_havereset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with rsp_ready held high; returns captured response
  task automatic xact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic [1:0] resp);
    bit got = 0;
    rdata = 32'hx;
    resp  = 2'bx;
    dmi.dmi_req_valid = 1'b1;
    dmi.dmi_req_op    = op;
    dmi.dmi_req_addr  = addr;
    dmi.dmi_req_data  = wdata;
    dmi.dmi_rsp_ready = 1'b1;
    tick();
    dmi.dmi_req_valid = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (dmi.dmi_rsp_valid) begin
        rdata = dmi.dmi_rsp_data;
        resp  = dmi.dmi_rsp_resp;
        got   = 1;
      end
      tick();
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL xact_timeout addr=%h op=%0d: no response within 8 cycles", addr, op);
    end
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] d);
    logic [31:0] r; logic [1:0] s;
    xact(2'd2, addr, d, r, s);
  endtask

  task automatic rd_check(input string name, input logic [6:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic [1:0] s;
    xact(2'd1, addr, 32'h0, r, s);
    n_cmp++;
    if (r !== exp || s !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got data=%h resp=%0d, expected data=%h resp=0", name, r, s, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({dmi.dmi_req_ready, dmi.dmi_rsp_valid, dmi.dmi_rsp_data, dmi.dmi_rsp_resp} !== {1'b1, 1'b0, 32'h0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_dmi: got ready=%b valid=%b data=%h resp=%0d, expected 1 0 0 0",
               dmi.dmi_req_ready, dmi.dmi_rsp_valid, dmi.dmi_rsp_data, dmi.dmi_rsp_resp);
    end
    n_cmp++;
    if ({haltreq, resumereq, resethaltreq, ndmreset, hartreset} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b, expected 00000", {haltreq, resumereq, resethaltreq, ndmreset, hartreset});
    end
  endtask

  task automatic test_regmap();
    wr(7'h10, 32'h0000_0001);
    rd_check("dmstatus_running", 7'h11, 32'h0000_0C82);
    rd_check("dmcontrol_active", 7'h10, 32'h0000_0001);
    rd_check("abstractcs",       7'h16, 32'h0000_0001);
    rd_check("hartinfo",         7'h12, 32'h0000_0000);
    rd_check("unmapped",         7'h20, 32'h0000_0000);
  endtask

  task automatic test_halt();
    bit seen = 0;
    dmi.dmi_req_valid = 1'b1;
    dmi.dmi_req_op    = 2'd2;
    dmi.dmi_req_addr  = 7'h10;
    dmi.dmi_req_data  = 32'h8000_0001;
    dmi.dmi_rsp_ready = 1'b1;
    tick();
    dmi.dmi_req_valid = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      if (haltreq === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL haltreq_latency: haltreq=%b after 2 cycles, expected 1", haltreq);
    end
    tick(); tick();
    hart_halted = 1'b1;
    rd_check("dmstatus_halted", 7'h11, 32'h0000_0382);
    rd_check("dmcontrol_halt",  7'h10, 32'h8000_0001);
  endtask

  task automatic test_resume();
    wr(7'h10, 32'h4000_0001);
    n_cmp++;
    if (resumereq !== 1'b1 || haltreq !== 1'b0) begin
      n_fail++;
      $display("FAIL resumereq_set: got resumereq=%b haltreq=%b, expected 1 0", resumereq, haltreq);
    end
    hart_resumeack = 1'b1;
    tick();
    hart_resumeack = 1'b0;
    hart_halted    = 1'b0;
    n_cmp++;
    if (resumereq !== 1'b0) begin
      n_fail++;
      $display("FAIL resumereq_ack: got %b, expected 0", resumereq);
    end
    rd_check("dmstatus_resumeack", 7'h11, 32'h0003_0C82);
    wr(7'h10, 32'hC000_0001);
    n_cmp++;
    if (resumereq !== 1'b0 || haltreq !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_with_halt: got resumereq=%b haltreq=%b, expected 0 1", resumereq, haltreq);
    end
    rd_check("resumeack_kept", 7'h11, 32'h0003_0C82);
    wr(7'h10, 32'h0000_0001);
  endtask

  task automatic test_resethalt();
    wr(7'h10, 32'h0000_0009);
    n_cmp++;
    if (resethaltreq !== 1'b1) begin
      n_fail++;
      $display("FAIL resethalt_set: got %b, expected 1", resethaltreq);
    end
    wr(7'h10, 32'h0000_000D);
    n_cmp++;
    if (resethaltreq !== 1'b0) begin
      n_fail++;
      $display("FAIL resethalt_both: got %b, expected 0", resethaltreq);
    end
  endtask

  task automatic test_havereset();
    wr(7'h10, 32'h0000_0003);
    n_cmp++;
    if (ndmreset !== 1'b1) begin
      n_fail++;
      $display("FAIL ndmreset_set: got %b, expected 1", ndmreset);
    end
    wr(7'h10, 32'h0000_0001);
    rd_check("havereset_ndm", 7'h11, 32'h000F_0C82);
    wr(7'h10, 32'h1000_0001);
    rd_check("havereset_ack", 7'h11, 32'h0003_0C82);
    hart_havereset = 1'b1;
    tick();
    hart_havereset = 1'b0;
    rd_check("havereset_hart", 7'h11, 32'h000F_0C82);
    wr(7'h10, 32'h2000_0001);
`ifdef DM_HARTRESET_EN
    rd_check("hartreset_rw", 7'h10, 32'h2000_0001);
    n_cmp++;
    if (hartreset !== 1'b1) begin
      n_fail++;
      $display("FAIL hartreset_port: got %b, expected 1", hartreset);
    end
    wr(7'h10, 32'h1000_0001);
    rd_check("hartreset_release", 7'h11, 32'h000F_0C82);
`else
    rd_check("hartreset_warl", 7'h10, 32'h0000_0001);
    n_cmp++;
    if (hartreset !== 1'b0) begin
      n_fail++;
      $display("FAIL hartreset_port: got %b, expected 0", hartreset);
    end
`endif
  endtask

  task automatic test_data0();
    wr(7'h04, 32'hDEAD_BEEF);
    rd_check("data0_rw", 7'h04, 32'hDEAD_BEEF);
    wr(7'h10, 32'h0000_0000);
    rd_check("data0_cleared", 7'h04, 32'h0000_0000);
    rd_check("flags_cleared", 7'h11, 32'h0000_0C82);
    wr(7'h04, 32'h1234_5678);
    wr(7'h10, 32'h8000_0001);
    n_cmp++;
    if (haltreq !== 1'b0) begin
      n_fail++;
      $display("FAIL inactive_write: haltreq=%b, expected 0", haltreq);
    end
    rd_check("data0_inactive", 7'h04, 32'h0000_0000);
  endtask

  task automatic test_reserved_hold();
    dmi.dmi_req_valid = 1'b1;
    dmi.dmi_req_op    = 2'd3;
    dmi.dmi_req_addr  = 7'h04;
    dmi.dmi_req_data  = 32'hFFFF_FFFF;
    dmi.dmi_rsp_ready = 1'b0;
    tick();
    dmi.dmi_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({dmi.dmi_rsp_valid, dmi.dmi_rsp_data, dmi.dmi_rsp_resp, dmi.dmi_req_ready} !== {1'b1, 32'h0, 2'd2, 1'b0}) begin
        n_fail++;
        $display("FAIL rsvd_hold[%0d]: got valid=%b data=%h resp=%0d ready=%b, expected 1 0 2 0",
                 i, dmi.dmi_rsp_valid, dmi.dmi_rsp_data, dmi.dmi_rsp_resp, dmi.dmi_req_ready);
      end
      tick();
    end
    dmi.dmi_rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (dmi.dmi_rsp_valid !== 1'b0 || dmi.dmi_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rsvd_consume: got valid=%b ready=%b, expected 0 1", dmi.dmi_rsp_valid, dmi.dmi_req_ready);
    end
    rd_check("rsvd_no_effect", 7'h04, 32'h0000_0000);
  endtask

  task automatic test_reset_mid();
    wr(7'h10, 32'h0000_0001);
    wr(7'h10, 32'h8000_0001);
    dmi.dmi_req_valid = 1'b1;
    dmi.dmi_req_op    = 2'd1;
    dmi.dmi_req_addr  = 7'h11;
    dmi.dmi_rsp_ready = 1'b0;
    tick();
    dmi.dmi_req_valid = 1'b0;
    tick();
    n_cmp++;
    if (dmi.dmi_rsp_valid !== 1'b1 || haltreq !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_resp: got valid=%b haltreq=%b, expected 1 1", dmi.dmi_rsp_valid, haltreq);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({dmi.dmi_rsp_valid, haltreq, dmi.dmi_req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b haltreq=%b ready=%b, expected 0 0 1",
               dmi.dmi_rsp_valid, haltreq, dmi.dmi_req_ready);
    end
    dmi.dmi_rsp_ready = 1'b1;
    rd_check("after_reset_ctl", 7'h10, 32'h0000_0000);
  endtask

  initial begin
    rst_n             = 1'b0;
    hart_halted       = 1'b0;
    hart_resumeack    = 1'b0;
    hart_havereset    = 1'b0;
    dmi.dmi_req_valid = 1'b0;
    dmi.dmi_req_addr  = '0;
    dmi.dmi_req_data  = '0;
    dmi.dmi_req_op    = 2'd0;
    dmi.dmi_rsp_ready = 1'b1;
    test_reset();
    test_regmap();
    test_halt();
    test_resume();
    test_resethalt();
    test_havereset();
    test_data0();
    test_reserved_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_module.md
Name: debug_module

Overview:
RISC-V debug module (DM) that answers DMI requests issued by the JTAG debug transport and drives the run-control inputs of the core (haltreq, resumereq, resethaltreq), plus a non-debug-module reset.
- Sits between the debug transport's DMI request/response channel and rv_core.
- Single hart; DMI register subset only.
- No abstract commands, program buffer or system bus access.

Parameters:
ABITS, 7, DMI address width
DM_VERSION, 4'd2, dmstatus.version value (debug spec 0.13)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous active-low
dmi_req_valid  in  1  request valid
dmi_req_ready  out  1  request accepted when valid&ready
dmi_req_addr  in  ABITS  DM register address
dmi_req_data  in  32  write data
dmi_req_op  in  2  0=nop, 1=read, 2=write, 3=reserved
dmi_rsp_valid  out  1  response valid
dmi_rsp_ready  in  1  response consumed when valid&ready
dmi_rsp_data  out  32  read data (0 for nop/write)
dmi_rsp_resp  out  2  0=success, 2=failed
haltreq  out  1  halt request to core (level)
resumereq  out  1  resume request to core (level until ack)
resethaltreq  out  1  halt-on-reset request to core
ndmreset  out  1  system reset request, excludes DM and transport
hartreset  out  1  hart-only reset (driven by the optional feature)
hart_halted  in  1  core is halted
hart_resumeack  in  1  one-cycle pulse: core has resumed
hart_havereset  in  1  one-cycle pulse: hart left reset

Behaviour:
Reset (rst_n=0 at a clk edge):
- All registers clear; FSM goes to IDLE.
- Outputs: dmi_req_ready=1, dmi_rsp_valid=0, dmi_rsp_data=0, dmi_rsp_resp=0, and haltreq, resumereq, resethaltreq, ndmreset, hartreset all 0.
- Reset mid-transaction drops the pending response.

FSM states and transitions:
- IDLE: req_ready=1. On valid -> capture addr/data/op -> ACCESS.
- ACCESS: req_ready=0. Perform the register read/write, register the response -> RESP.
- RESP: rsp_valid=1 and the response is held stable until rsp_ready -> IDLE.
- One outstanding transaction only. Minimum turnaround is 3 cycles (accept, access, respond).
- rsp_ready already high in RESP: response is consumed that cycle and the next request may be accepted in the following cycle.

Register map:
- 0x04 data0: RW scratch, 32 bits.
- 0x10 dmcontrol:
  - haltreq[31], resumereq[30] (W1), hartreset[29], ackhavereset[28] (W1), setresethaltreq[3] (W1), clrresethaltreq[2] (W1), ndmreset[1], dmactive[0].
  - Reads return haltreq, hartreset, ndmreset and dmactive; W1 bits read 0.
- 0x11 dmstatus (RO):
  - version[3:0]=DM_VERSION, authenticated[7]=1.
  - any/allhalted[9:8]=hart_halted, any/allrunning[11:10]=!hart_halted.
  - any/allresumeack[17:16]=resumeack flag, any/allhavereset[19:18]=havereset flag.
  - Other bits 0.
- 0x12 hartinfo: reads 0.
- 0x16 abstractcs: reads datacount[3:0]=1, all else 0; writes ignored.
- Other addresses: reads return 0 with success; writes are ignored with success.
- op=3 returns resp=2 with data 0 and no side effects. op=0 returns success with data 0.

dmactive gating:
- dmactive=0 holds every other DM state at 0: data0, control bits, flags, outputs.
- Writes with dmactive=0 update only dmactive.

Run control:
- haltreq output equals dmcontrol.haltreq.
- Writing resumereq=1 while haltreq=0 clears the resumeack flag and sets resumereq.
- resumereq drops and the resumeack flag sets on hart_resumeack.
- resumereq=1 written together with haltreq=1 is ignored.
- Resethaltreq flag: setresethaltreq sets it, clrresethaltreq clears it; clear wins when both are written.
- Havereset flag: set by hart_havereset or by ndmreset 1->0, cleared by ackhavereset. A set event in the same cycle wins over the clear.

Optional Feature:
DM_HARTRESET_EN
- Defined: dmcontrol.hartreset is RW and drives the hartreset port. Releasing it (1->0) sets the havereset flag.
- Undefined: the bit is WARL 0 (reads 0, writes ignored) and hartreset is tied 0.

Decomposition:
- Package dm_pkg:
  - DMI op/resp enums.
  - Register address localparams.
  - Packed struct typedefs for dmcontrol and dmstatus.
  - FSM state enum.
- Sub-module dm_dmi_slave: request/response FSM and capture registers. It presents a one-cycle register-access strobe to the parent, which holds the register file and run-control logic.

Test Plan:
- Write 0x10=0x00000001, then read 0x11 with hart_halted=0 -> rsp_data=0x00000C82, resp=0.
- Write 0x10=0x80000001 -> haltreq=1 within 2 cycles of the request handshake. Then set hart_halted=1 and read 0x11 -> bits[9:8]=2'b11.
- While halted, write 0x10=0x40000001 -> resumereq=1. Pulse hart_resumeack -> resumereq=0 next cycle, and dmstatus[17:16]=2'b11.
- Write data0=0xDEADBEEF with dmactive=1 and read it back -> 0xDEADBEEF. Write 0x10=0, then read data0 -> 0x00000000.
- Issue op=3 -> resp=2, data=0. Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_resp stable and req_ready=0 throughout.
- Assert rst_n=0 while in RESP with haltreq=1 -> next cycle rsp_valid=0, haltreq=0, req_ready=1.
